// File: rtl/beacon_update_parser_if.sv
// beacon_update_parser_if: 134-bit packet bus entering and leaving the update parser
interface beacon_update_parser_if;
    logic         in_data_wr;
    logic [133:0] in_data;
    logic         in_data_valid;
    logic         in_data_valid_wr;
    logic         out_data_wr;
    logic [133:0] out_data;
    logic         out_data_valid;
    logic         out_data_valid_wr;

    modport master (
        output in_data_wr, in_data, in_data_valid, in_data_valid_wr,
        input  out_data_wr, out_data, out_data_valid, out_data_valid_wr
    );

    modport slave (
        input  in_data_wr, in_data, in_data_valid, in_data_valid_wr,
        output out_data_wr, out_data, out_data_valid, out_data_valid_wr
    );
endinterface

// File: rtl/beacon_update_parser.sv
// beacon_update_parser: consumes CNC beacon update packets, forwards everything else with 3-cycle latency
module beacon_update_parser #(
    parameter logic [15:0] ETH_TYPE    = 16'h88f7,
    parameter logic [3:0]  UPDATE_TYPE = 4'hd,
    parameter logic [31:0] DEF_TBP     = 32'h0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    beacon_update_parser_if.slave        bus,
    input  logic [47:0]                  local_mac_addr,
    output logic                         direction,
    output logic [31:0]                  token_bucket_para,
    output logic [47:0]                  direct_mac_addr,
    output logic                         beacon_update_master,
    output logic [15:0]                  update_seq,
    output logic [15:0]                  update_cnt,
    output logic [15:0]                  err_cnt
);
    typedef enum logic [1:0] {IDLE, HDR, FWD, DROP} state_t;

    // hdr marks words of the packet still being classified so they can be dropped retroactively
    typedef struct packed {
        logic         wr;
        logic [133:0] data;
        logic         valid;
        logic         valid_wr;
        logic         drop;
        logic         hdr;
    } stage_t;

    state_t       r_state, w_state_nxt;
    logic [2:0]   r_wcnt, w_idx;
    stage_t       r_s1, r_s2, r_s3;
    logic         w_head, w_tail, w_match;
    logic         w_match_now, w_drop_in, w_hdr_in;
    logic         w_cap_seq, w_cap_w6, w_commit, w_err;
    logic [15:0]  r_sh_seq;
    logic         r_sh_dir;
    logic [31:0]  r_sh_tbp;
    logic [47:0]  r_sh_mac;
    logic         r_sh_w6;
    logic         r_direction;
    logic [31:0]  r_tbp;
    logic [47:0]  r_mac;
    logic         r_master;
    logic [15:0]  r_update_seq;
    logic [15:0]  r_update_cnt;
    logic [15:0]  r_err_cnt;

    function automatic stage_t f_adv(input stage_t s, input logic mark, input logic clr);
        f_adv      = s;
        f_adv.drop = s.drop | (mark & s.hdr & s.wr);
        f_adv.hdr  = s.hdr & ~clr;
    endfunction

    assign w_head  = bus.in_data_wr && bus.in_data[133:132] == 2'b01;
    assign w_tail  = bus.in_data_wr && bus.in_data[133:132] == 2'b10;
    assign w_idx   = w_head ? 3'd0 : (r_wcnt == 3'd7 ? 3'd7 : r_wcnt + 3'd1);
    assign w_match = bus.in_data[127:80] == local_mac_addr &&
                     bus.in_data[31:16] == ETH_TYPE &&
                     bus.in_data[11:8] == UPDATE_TYPE;

    // next state, classification and commit/abort decisions for the current word
    always_comb begin
        w_state_nxt = r_state;
        w_match_now = 1'b0;
        w_cap_seq   = 1'b0;
        w_cap_w6    = 1'b0;
        w_commit    = 1'b0;
        w_err       = 1'b0;
        if (bus.in_data_wr) begin
            if (w_head) begin
                w_state_nxt = HDR;
                w_err       = r_state == DROP;
            end else begin
                case (r_state)
                    HDR: begin
                        if (w_idx == 3'd2) begin
                            w_match_now = w_match;
                            w_state_nxt = w_tail ? IDLE : (w_match ? DROP : FWD);
                            w_err       = w_match && w_tail;
                        end else if (w_tail) begin
                            w_state_nxt = IDLE;
                        end
                    end
                    FWD: w_state_nxt = w_tail ? IDLE : FWD;
                    DROP: begin
                        w_cap_seq = w_idx == 3'd4;
                        w_cap_w6  = w_idx == 3'd6;
                        if (w_tail) begin
                            w_state_nxt = IDLE;
                            w_commit    = (r_sh_w6 || w_cap_w6) && bus.in_data_valid_wr && bus.in_data_valid;
                            w_err       = !w_commit;
                        end
                    end
                    default: w_state_nxt = IDLE;
                endcase
            end
        end
    end

    assign w_drop_in = w_match_now || (r_state == DROP && !w_head);
    assign w_hdr_in  = bus.in_data_wr && (w_head || r_state == HDR);

    // state register and word index within the packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.in_data_wr)
                r_wcnt <= w_idx;
        end
    end

    // 3-stage delay line; a match at w2 retroactively drops the header words already inside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= '{wr: bus.in_data_wr, data: bus.in_data, valid: bus.in_data_valid,
                      valid_wr: bus.in_data_valid_wr, drop: w_drop_in, hdr: w_hdr_in};
            r_s2 <= f_adv(r_s1, w_match_now, w_head);
            r_s3 <= f_adv(r_s2, w_match_now, w_head);
        end
    end

    assign bus.out_data_wr       = r_s3.wr & ~r_s3.drop;
    assign bus.out_data          = r_s3.drop ? 134'd0 : r_s3.data;
    assign bus.out_data_valid    = r_s3.valid & ~r_s3.drop;
    assign bus.out_data_valid_wr = r_s3.valid_wr & ~r_s3.drop;

    // shadow copies of the update fields, held until the tail decides whether to commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_seq <= 16'd0;
            r_sh_dir <= 1'b0;
            r_sh_tbp <= 32'd0;
            r_sh_mac <= 48'd0;
            r_sh_w6  <= 1'b0;
        end else begin
            if (w_match_now)
                r_sh_w6 <= 1'b0;
            if (w_cap_seq)
                r_sh_seq <= bus.in_data[31:16];
            if (w_cap_w6) begin
                r_sh_mac <= bus.in_data[127:80];
                r_sh_dir <= bus.in_data[79];
                r_sh_tbp <= bus.in_data[63:32];
                r_sh_w6  <= 1'b1;
            end
        end
    end

    // committed configuration; w6 may itself be the tail, so take it straight from the bus then
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_direction  <= 1'b0;
            r_tbp        <= DEF_TBP;
            r_mac        <= 48'd0;
            r_update_seq <= 16'd0;
            r_master     <= 1'b0;
        end else if (w_commit) begin
            r_direction  <= w_cap_w6 ? bus.in_data[79] : r_sh_dir;
            r_tbp        <= w_cap_w6 ? bus.in_data[63:32] : r_sh_tbp;
            r_mac        <= w_cap_w6 ? bus.in_data[127:80] : r_sh_mac;
            r_update_seq <= r_sh_seq;
            r_master     <= ~r_master;
        end
    end

    // saturating commit and abort counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_update_cnt <= 16'd0;
            r_err_cnt    <= 16'd0;
        end else begin
            if (w_commit && r_update_cnt != 16'hFFFF)
                r_update_cnt <= r_update_cnt + 16'd1;
            if (w_err && r_err_cnt != 16'hFFFF)
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign direction            = r_direction;
    assign token_bucket_para    = r_tbp;
    assign direct_mac_addr      = r_mac;
    assign beacon_update_master = r_master;
    assign update_seq           = r_update_seq;
    assign update_cnt           = r_update_cnt;
    assign err_cnt              = r_err_cnt;
endmodule

// File: tb/tb_beacon_update_parser.sv
// tb_beacon_update_parser: directed packets with a scoreboard checking forwarded words and committed config
module tb_beacon_update_parser;
    localparam logic [47:0] LOCAL = 48'h000606020001;

    typedef logic [127:0] pkt_t [8];
    typedef struct {
        logic [133:0] data;
        logic         valid;
        logic         valid_wr;
        int           cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] local_mac_addr = LOCAL;
    logic        direction;
    logic [31:0] token_bucket_para;
    logic [47:0] direct_mac_addr;
    logic        beacon_update_master;
    logic [15:0] update_seq;
    logic [15:0] update_cnt;
    logic [15:0] err_cnt;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    exp_t        q[$];
    pkt_t        pk;

    beacon_update_parser_if bus();

    beacon_update_parser dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .bus                  (bus),
        .local_mac_addr       (local_mac_addr),
        .direction            (direction),
        .token_bucket_para    (token_bucket_para),
        .direct_mac_addr      (direct_mac_addr),
        .beacon_update_master (beacon_update_master),
        .update_seq           (update_seq),
        .update_cnt           (update_cnt),
        .err_cnt              (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // every forwarded word must match the oldest pending expectation, including its arrival cycle
    always @(negedge clk) begin
        if (rst_n && bus.out_data_wr) begin
            if (q.size() == 0) begin
                chk("unexpected_word", bus.out_data, 134'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("fwd_data", bus.out_data, e.data);
                chk("fwd_valid", 134'(bus.out_data_valid), 134'(e.valid));
                chk("fwd_valid_wr", 134'(bus.out_data_valid_wr), 134'(e.valid_wr));
                chk("fwd_latency", 134'(cyc), 134'(e.cyc));
            end
        end
    end

    function automatic logic [127:0] w2f(input logic [47:0] dmac, input logic [15:0] eth, input logic [3:0] typ);
        return {dmac, 48'h0000AABBCCDD, eth, 4'h0, typ, 8'h00};
    endfunction

    task automatic zero_in();
        bus.in_data_wr       = 1'b0;
        bus.in_data          = '0;
        bus.in_data_valid    = 1'b0;
        bus.in_data_valid_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            zero_in();
        end
    endtask

    task automatic send(input logic [1:0] t, input logic [127:0] d, input logic vld, input logic fwd);
        exp_t e;
        @(posedge clk);
        #1;
        bus.in_data_wr       = 1'b1;
        bus.in_data          = {t, (t == 2'b10) ? 4'h3 : 4'h0, d};
        bus.in_data_valid_wr = t == 2'b10;
        bus.in_data_valid    = (t == 2'b10) ? vld : 1'b0;
        if (fwd) begin
            e.data     = bus.in_data;
            e.valid    = bus.in_data_valid;
            e.valid_wr = bus.in_data_valid_wr;
            e.cyc      = cyc + 3;
            q.push_back(e);
        end
    endtask

    task automatic send_pkt(input int n, input logic vld, input logic fwd);
        for (int i = 0; i < n; i++)
            send(i == 0 ? 2'b01 : (i == n - 1 ? 2'b10 : 2'b11), pk[i], vld, fwd);
    endtask

    task automatic mk_upd(input logic [47:0] dmac, input logic [15:0] seq, input logic [47:0] mac,
                          input logic dir, input logic [31:0] tbp);
        pk[0] = 128'h000102030405060708090A0B0C0D0E0F;
        pk[1] = 128'hF0E0D0C0B0A090807060504030201000;
        pk[2] = w2f(dmac, 16'h88f7, 4'hd);
        pk[3] = 128'h33333333333333333333333333333333;
        pk[4] = {96'h0, seq, 16'h0};
        pk[5] = 128'h5555AAAA5555AAAA5555AAAA5555AAAA;
        pk[6] = {mac, dir, 15'h0, tbp, 32'h0};
        pk[7] = 128'h7777777777777777DEADBEEFCAFEF00D;
    endtask

    task automatic chk_cfg(input logic dir, input logic [31:0] tbp, input logic [47:0] mac,
                           input logic m, input logic [15:0] seq, input logic [15:0] uc, input logic [15:0] ec);
        chk("direction", 134'(direction), 134'(dir));
        chk("token_bucket_para", 134'(token_bucket_para), 134'(tbp));
        chk("direct_mac_addr", 134'(direct_mac_addr), 134'(mac));
        chk("beacon_update_master", 134'(beacon_update_master), 134'(m));
        chk("update_seq", 134'(update_seq), 134'(seq));
        chk("update_cnt", 134'(update_cnt), 134'(uc));
        chk("err_cnt", 134'(err_cnt), 134'(ec));
    endtask

    initial begin
        zero_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_wr", 134'(bus.out_data_wr), 134'd0);
        chk("rst_out_data", bus.out_data, 134'd0);
        chk_cfg(1'b0, 32'h0, 48'h0, 1'b0, 16'h0, 16'd0, 16'd0);
        rst_n = 1'b1;
        idle(2);

        mk_upd(LOCAL, 16'h0005, 48'h112233445566, 1'b1, 32'h00010040);
        send_pkt(8, 1'b1, 1'b0);
        idle(1);
        chk_cfg(1'b1, 32'h00010040, 48'h112233445566, 1'b1, 16'h0005, 16'd1, 16'd0);
        idle(4);

        mk_upd(LOCAL, 16'h0009, 48'hFFEEDDCCBBAA, 1'b0, 32'h12345678);
        pk[2] = w2f(LOCAL, 16'h0800, 4'hd);
        send_pkt(5, 1'b1, 1'b1);
        idle(6);
        chk_cfg(1'b1, 32'h00010040, 48'h112233445566, 1'b1, 16'h0005, 16'd1, 16'd0);

        mk_upd(48'h000606020002, 16'h0011, 48'h010203040506, 1'b0, 32'h0000FFFF);
        send_pkt(8, 1'b1, 1'b1);
        idle(6);
        chk_cfg(1'b1, 32'h00010040, 48'h112233445566, 1'b1, 16'h0005, 16'd1, 16'd0);

        mk_upd(LOCAL, 16'h0021, 48'h0A0B0C0D0E0F, 1'b0, 32'h0BADF00D);
        send_pkt(5, 1'b1, 1'b0);
        idle(2);
        chk_cfg(1'b1, 32'h00010040, 48'h112233445566, 1'b1, 16'h0005, 16'd1, 16'd1);
        send_pkt(8, 1'b0, 1'b0);
        idle(2);
        chk_cfg(1'b1, 32'h00010040, 48'h112233445566, 1'b1, 16'h0005, 16'd1, 16'd2);
        idle(3);

        mk_upd(LOCAL, 16'h0007, 48'hA1B2C3D4E5F6, 1'b0, 32'h00020080);
        send_pkt(8, 1'b1, 1'b0);
        mk_upd(LOCAL, 16'h0000, 48'h0, 1'b1, 32'h0);
        pk[2] = w2f(LOCAL, 16'h0806, 4'h0);
        send_pkt(4, 1'b1, 1'b1);
        idle(6);
        chk_cfg(1'b0, 32'h00020080, 48'hA1B2C3D4E5F6, 1'b0, 16'h0007, 16'd2, 16'd2);

        mk_upd(LOCAL, 16'h0042, 48'h665544332211, 1'b1, 32'h00000777);
        for (int i = 0; i < 3; i++)
            send(i == 0 ? 2'b01 : 2'b11, pk[i], 1'b0, 1'b0);
        @(posedge clk);
        #1;
        zero_in();
        rst_n = 1'b0;
        #1;
        chk("arst_out_wr", 134'(bus.out_data_wr), 134'd0);
        chk("arst_out_data", bus.out_data, 134'd0);
        chk_cfg(1'b0, 32'h0, 48'h0, 1'b0, 16'h0, 16'd0, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        send_pkt(8, 1'b1, 1'b0);
        idle(1);
        chk_cfg(1'b1, 32'h00000777, 48'h665544332211, 1'b1, 16'h0042, 16'd1, 16'd0);

        idle(10);
        chk("drain", 134'(q.size()), 134'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/beacon_update_parser.md
Name: beacon_update_parser

Overview:
- Ingress-side receiver for CNC beacon update messages carried on the 134-bit packet bus. This is the counterpart of the beacon report generator.
- Classifies each incoming packet at its third word.
  - Matching update packets are consumed: the block latches the new direction, token bucket and direct-MAC configuration, then toggles beacon_update_master so the next beacon report carries the acknowledge type 4'he.
  - All other packets pass through with fixed 3-cycle latency.

Parameters:
- ETH_TYPE, 16'h88f7, required ethertype.
- UPDATE_TYPE, 4'hd, required message-type nibble.
- DEF_TBP, 32'h0, reset value of token_bucket_para.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- in_data_wr  input  1  word strobe
- in_data  input  134  [133:132] 01 head / 11 body / 10 tail; [131:128] invalid bytes; [127:0] data
- in_data_valid  input  1  packet-good flag, meaningful with in_data_valid_wr
- in_data_valid_wr  input  1  valid strobe, asserted on tail cycle
- local_mac_addr  input  48  this node's MAC
- out_data_wr  output  1  forwarded word strobe
- out_data  output  134  forwarded word
- out_data_valid  output  1  forwarded valid
- out_data_valid_wr  output  1  forwarded valid strobe
- direction  output  1  configured direction
- token_bucket_para  output  32  configured token bucket parameter
- direct_mac_addr  output  48  configured neighbour MAC
- beacon_update_master  output  1  toggles once per committed update
- update_seq  output  16  sequence number of last committed update
- update_cnt  output  16  committed updates, saturating
- err_cnt  output  16  aborted updates, saturating

Behaviour:
Reset values:
- All out_* = 0; direction = 0; token_bucket_para = DEF_TBP; direct_mac_addr = 0.
- beacon_update_master = 0; update_seq = 0; counters = 0.
- Pipeline and state are cleared; a packet in flight at reset is lost entirely.

Word index:
- wcnt (3-bit) = 0 on a head word, +1 on each subsequent in_data_wr word, saturating at 7.

Packet layout:
- w0, w1: metadata.
- w2: {dmac[127:80], smac[79:32], ethertype[31:16], 4'b0, type[11:8], 8'b0}.
- w4: seq[31:16].
- w6: {direct_mac[127:80], direction[79], 15'b0, tbp[63:32], 32'b0}.

Match condition, evaluated combinationally on w2:
- dmac == local_mac_addr, ethertype == ETH_TYPE and type == UPDATE_TYPE.

State machine:
- IDLE: on a head word go to HDR. A non-head word with wr=1 is forwarded unparsed.
- HDR (w0..w2):
  - At w2: match -> DROP, no match -> FWD.
  - A tail before w2 forwards the packet -> IDLE.
- FWD: forward words. Tail -> IDLE.
- DROP:
  - Capture the w4 seq and w6 fields into shadow registers.
  - On tail, commit only if w6 was captured and in_data_valid=1 at the tail cycle. Otherwise err_cnt+1, no commit. Either way -> IDLE.
- A head word arriving in HDR/FWD/DROP aborts the current packet:
  - An aborted DROP packet counts err_cnt+1 and is not committed.
  - The new packet is parsed from w0.

Pipeline:
- 3-stage shift register of {wr, data, valid, valid_wr, drop}.
- Outputs equal stage 3 when drop=0; all-zero when drop=1.
- At a w2 match, the drop bit is set on the stages holding w0 and w1 and on incoming w2. All later words of the packet, including the valid_wr pulse, enter with drop=1.
- Forwarded packets are bit-identical with exactly 3 cycles of latency.
- Back-to-back packets with zero gap are supported.

Commit (at the cycle after the tail):
- direction, token_bucket_para, direct_mac_addr and update_seq take the shadow values.
- beacon_update_master inverts; update_cnt increments.
- Counters saturate at 16'hFFFF.

Test Plan:
- Update packet, 8 words, dmac = local 0x000606020001, w4 seq = 16'h0005, w6 = {48'h112233445566, 1'b1, 15'b0, 32'h00010040, 32'b0}, valid=1 -> out_data_wr = 0 throughout. One cycle after the tail: direction = 1, token_bucket_para = 32'h00010040, direct_mac_addr = 48'h112233445566, update_seq = 5, beacon_update_master 0->1, update_cnt = 1.
- 5-word packet with ethertype 16'h0800 -> emerges bit-identical starting 3 cycles after input, valid_wr pulse included; configuration registers unchanged.
- Update packet with dmac 0x000606020002 != local -> forwarded unchanged, no commit.
- Update packet with tail at w4 -> nothing forwarded, err_cnt = 1, beacon_update_master and configuration unchanged. Repeat with full length but valid=0 at tail -> err_cnt = 2.
- Matching update immediately followed, with zero gap, by a non-matching 4-word packet -> first packet consumed and committed; second emerges intact 3 cycles after its own input.
- rst_n low for 1 cycle during w3 of an update -> all outputs return to reset values immediately, no commit. A following update packet commits normally with update_cnt = 1.
